// File: rtl/arith_core_sequencer_pkg.sv
// arith_core_sequencer_pkg: shared state encoding and parameter defaults for the arithmetic core sequencer
package arith_core_sequencer_pkg;
    localparam int STEP_W_DEF    = 3;
    localparam int PIX_W_DEF     = 16;
    localparam int DRAIN_LAT_DEF = 4;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/arith_core_sequencer_if.sv
// arith_core_sequencer_if: operand-buffer handshake and core control bundle between sequencer and core
interface arith_core_sequencer_if
    import arith_core_sequencer_pkg::*;
#(
    parameter int STEP_W = STEP_W_DEF
);
    logic              data_valid;
    logic              data_ready;
    logic              core_en;
    logic [STEP_W-1:0] core_step;
    logic [1:0]        core_bound_level;
    logic              core_en_relu;
    logic              core_en_mp;
    logic              core_out_en;
    modport master(
        input  data_valid, core_out_en,
        output data_ready, core_en, core_step, core_bound_level, core_en_relu, core_en_mp
    );
    modport slave(
        output data_valid, core_out_en,
        input  data_ready, core_en, core_step, core_bound_level, core_en_relu, core_en_mp
    );
endinterface

// File: rtl/arith_core_sequencer_step_counter.sv
// seq_step_counter: step index that wraps at last_step and bumps the pixel index in the same edge
module seq_step_counter
    import arith_core_sequencer_pkg::*;
#(
    parameter int STEP_W = STEP_W_DEF,
    parameter int PIX_W  = PIX_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    input  logic [STEP_W-1:0] last_step,
    input  logic [PIX_W-1:0]  last_pixel,
    output logic [STEP_W-1:0] step,
    output logic              done
);
    logic [STEP_W-1:0] step_d, step_q;
    logic [PIX_W-1:0]  pix_d, pix_q;
    logic              wrap;

    assign wrap = step_q == last_step;
    assign done = wrap && pix_q == last_pixel;
    assign step = step_q;

    always_comb begin
        step_d = clr ? '0 : inc ? (wrap ? '0 : step_q + STEP_W'(1)) : step_q;
        pix_d  = clr ? '0 : (inc && wrap) ? pix_q + PIX_W'(1) : pix_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_q <= '0;
            pix_q  <= '0;
        end else begin
            step_q <= step_d;
            pix_q  <= pix_d;
        end
    end
endmodule

// File: rtl/arith_core_sequencer.sv
// arith_core_sequencer: steps the core through cfg_pixels x (cfg_last_step+1) windows, drains, then pulses done
module arith_core_sequencer
    import arith_core_sequencer_pkg::*;
#(
    parameter int STEP_W    = STEP_W_DEF,
    parameter int PIX_W     = PIX_W_DEF,
    parameter int DRAIN_LAT = DRAIN_LAT_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [STEP_W-1:0]      cfg_last_step,
    input  logic [PIX_W-1:0]       cfg_pixels,
    input  logic [1:0]             cfg_bound_level,
    input  logic                   cfg_relu,
    input  logic                   cfg_mp,
    arith_core_sequencer_if.master core,
    output logic                   busy,
    output logic                   done,
    output logic [PIX_W-1:0]       out_cnt
);
    localparam int DW = $clog2(DRAIN_LAT + 1);

    state_e            state_d, state_q;
    logic [STEP_W-1:0] last_step_d, last_step_q;
    logic [PIX_W-1:0]  pixels_d, pixels_q, out_cnt_d, out_cnt_q;
    logic [1:0]        bound_d, bound_q;
    logic              relu_d, relu_q, mp_d, mp_q;
    logic [DW-1:0]     drain_d, drain_q;
    logic              launch, accept, live, job_done;

    assign launch = state_q == IDLE && start;
    assign accept = state_q == RUN && core.data_valid && !abort;
    assign live   = state_q == RUN || state_q == DRAIN;

    seq_step_counter #(.STEP_W(STEP_W), .PIX_W(PIX_W)) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .inc       (accept),
        .clr       (launch),
        .last_step (last_step_q),
        .last_pixel(pixels_q - PIX_W'(1)),
        .step      (core.core_step),
        .done      (job_done)
    );

    always_comb begin
        state_d     = state_q;
        drain_d     = '0;
        last_step_d = launch ? cfg_last_step : last_step_q;
        pixels_d    = launch ? cfg_pixels : pixels_q;
        bound_d     = launch ? cfg_bound_level : bound_q;
        relu_d      = launch ? cfg_relu : relu_q;
        mp_d        = launch ? cfg_mp : mp_q;
        out_cnt_d   = launch ? '0 :
                      (busy && core.core_out_en && !(&out_cnt_q)) ? out_cnt_q + PIX_W'(1) : out_cnt_q;
        case (state_q)
            IDLE:  if (start) state_d = cfg_pixels == '0 ? DONE : RUN;
            RUN:   if (abort) state_d = IDLE; else if (accept && job_done) state_d = DRAIN;
            DRAIN: begin
                drain_d = drain_q + DW'(1);
                if (abort) state_d = IDLE; else if (drain_q == DW'(DRAIN_LAT - 1)) state_d = DONE;
            end
            DONE:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            drain_q     <= '0;
            last_step_q <= '0;
            pixels_q    <= '0;
            bound_q     <= '0;
            relu_q      <= 1'b0;
            mp_q        <= 1'b0;
            out_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            last_step_q <= last_step_d;
            pixels_q    <= pixels_d;
            bound_q     <= bound_d;
            relu_q      <= relu_d;
            mp_q        <= mp_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    // the core pipelines these itself, so they must stay stable through DRAIN
    assign core.core_bound_level = live ? bound_q : '0;
    assign core.core_en_relu     = live && relu_q;
    assign core.core_en_mp       = live && mp_q;
    assign core.data_ready       = accept;
    assign core.core_en          = accept;
    assign busy                  = state_q != IDLE;
    assign done                  = state_q == DONE;
    assign out_cnt               = out_cnt_q;
endmodule

// File: tb/tb_arith_core_sequencer.sv
// tb_arith_core_sequencer: directed jobs checked against a per-cycle behavioural model plus literal expectations
module tb_arith_core_sequencer;
    localparam int DRAIN_LAT = 4;
    localparam int OUT_MAX   = 65535;

    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0;
    logic [2:0]  cfg_last_step = '0;
    logic [15:0] cfg_pixels = '0;
    logic [1:0]  cfg_bound_level = '0;
    logic        cfg_relu = 1'b0, cfg_mp = 1'b0;
    logic        data_valid = 1'b0, core_out_en = 1'b0;
    logic        busy, done;
    logic [15:0] out_cnt;
    int          total = 0, bad = 0;

    arith_core_sequencer_if #(.STEP_W(3)) core ();
    assign core.data_valid  = data_valid;
    assign core.core_out_en = core_out_en;

    arith_core_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_last_step(cfg_last_step), .cfg_pixels(cfg_pixels),
        .cfg_bound_level(cfg_bound_level), .cfg_relu(cfg_relu), .cfg_mp(cfg_mp),
        .core(core.master), .busy(busy), .done(done), .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: phase 0 idle, 1 run, 2 drain, 3 done; step/pixel derived from accepted-window count
    int m_ph = 0, m_acc = 0, m_per = 1, m_tot = 0, m_drain = 0, m_out = 0;
    int m_bl = 0, m_relu = 0, m_mp = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ph <= 0; m_acc <= 0; m_per <= 1; m_tot <= 0; m_drain <= 0; m_out <= 0;
            m_bl <= 0; m_relu <= 0; m_mp <= 0;
        end else begin
            if (m_ph != 0 && core_out_en && m_out < OUT_MAX) m_out <= m_out + 1;
            case (m_ph)
                0: if (start) begin
                    m_per  <= int'(cfg_last_step) + 1;
                    m_tot  <= (int'(cfg_last_step) + 1) * int'(cfg_pixels);
                    m_acc  <= 0;
                    m_out  <= 0;
                    m_bl   <= int'(cfg_bound_level);
                    m_relu <= int'(cfg_relu);
                    m_mp   <= int'(cfg_mp);
                    m_ph   <= cfg_pixels == 0 ? 3 : 1;
                end
                1: if (abort) m_ph <= 0;
                   else if (data_valid) begin
                       m_acc <= m_acc + 1;
                       if (m_acc + 1 == m_tot) begin m_ph <= 2; m_drain <= 0; end
                   end
                2: if (abort) m_ph <= 0;
                   else begin
                       m_drain <= m_drain + 1;
                       if (m_drain + 1 == DRAIN_LAT) m_ph <= 3;
                   end
                default: m_ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        automatic bit live = m_ph == 1 || m_ph == 2;
        automatic bit en   = m_ph == 1 && data_valid && !abort;
        chk("m_core_en", core.core_en, en);
        chk("m_data_ready", core.data_ready, en);
        chk("m_core_step", core.core_step, m_acc % m_per);
        chk("m_busy", busy, m_ph != 0);
        chk("m_done", done, m_ph == 3);
        chk("m_bound", core.core_bound_level, live ? m_bl : 0);
        chk("m_relu", core.core_en_relu, live ? m_relu : 0);
        chk("m_mp", core.core_en_mp, live ? m_mp : 0);
        chk("m_out_cnt", out_cnt, m_out);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int steps[$];
    int exp_seq[6] = '{0, 1, 2, 0, 1, 2};

    task automatic job(input int last, input int pix, input int stall_n, input bit chg,
                       output int done_c, output int drain_n);
        int acc = 0, stalled = 0, c;
        steps.delete();
        cfg_last_step = 3'(last);
        cfg_pixels    = 16'(pix);
        start = 1'b1;
        tick();
        start   = 1'b0;
        c       = 1;
        done_c  = -1;
        drain_n = 0;
        while (c < 60 && done_c < 0) begin
            data_valid  = !(acc == 1 && stalled < stall_n);
            core_out_en = chg && c[0];
            if (chg) begin
                cfg_relu = c[0]; cfg_mp = ~c[0]; cfg_bound_level = c[1:0]; cfg_pixels = 16'd5;
            end
            #1;
            if (core.core_en) begin steps.push_back(int'(core.core_step)); acc++; end
            if (!data_valid && busy) begin
                stalled++;
                chk("stall_step", core.core_step, 1);
                chk("stall_en", core.core_en, 0);
            end
            if (busy && !done && !core.core_en && data_valid) drain_n++;
            if (chg && busy && !done) begin
                chk("latched_bound", core.core_bound_level, 2);
                chk("latched_relu", core.core_en_relu, 1);
                chk("latched_mp", core.core_en_mp, 1);
            end
            if (done) done_c = c;
            tick();
            c++;
        end
        data_valid  = 1'b0;
        core_out_en = 1'b0;
        if (done_c < 0) chk("job_timeout", 0, 1);
    endtask

    task automatic chk_seq(input string nm);
        chk({nm, "_len"}, steps.size(), 6);
        for (int i = 0; i < steps.size() && i < 6; i++) chk({nm, "_step"}, steps[i], exp_seq[i]);
    endtask

    initial begin
        int dc, dn;
        bit saw;
        #2;
        chk("rst_outs", {busy, done, core.core_en, core.core_step, out_cnt}, 0);
        #10 reset = 1'b1;
        tick();

        data_valid = 1'b1;
        job(2, 2, 0, 0, dc, dn);
        chk("t1_done_cycle", dc, 11);
        chk("t1_drain", dn, 4);
        chk_seq("t1");
        chk("t1_idle", busy, 0);

        job(2, 2, 3, 0, dc, dn);
        chk("t2_done_cycle", dc, 14);
        chk_seq("t2");

        data_valid = 1'b1;
        job(2, 0, 0, 0, dc, dn);
        chk("t3_done_cycle", dc, 1);
        chk("t3_no_en", steps.size(), 0);

        cfg_last_step = 3'd2; cfg_pixels = 16'd2; data_valid = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        #1;
        chk("ab_en", core.core_en, 0);
        chk("ab_ready", core.data_ready, 0);
        chk("ab_step", core.core_step, 1);
        tick();
        abort = 1'b0;
        chk("ab_idle", busy, 0);
        chk("ab_no_done", done, 0);
        data_valid = 1'b1;
        job(2, 2, 0, 0, dc, dn);
        chk("ab_restart_done", dc, 11);

        cfg_bound_level = 2'd3; cfg_relu = 1'b1; cfg_mp = 1'b0;
        cfg_last_step = 3'd2; cfg_pixels = 16'd2; data_valid = 1'b1; core_out_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        chk("rd_pre_bound", core.core_bound_level, 3);
        chk("rd_pre_out", out_cnt, 7);
        #2 reset = 1'b0;
        #1;
        chk("rd_outs", {busy, done, core.core_en, core.data_ready, core.core_step,
                        core.core_bound_level, core.core_en_relu, core.core_en_mp, out_cnt}, 0);
        core_out_en = 1'b0;
        @(posedge clk);
        #3 reset = 1'b1;
        tick();
        chk("rd_idle", busy, 0);
        saw = 1'b0;
        repeat (12) begin tick(); saw |= done; end
        chk("rd_no_done", saw, 0);

        cfg_bound_level = 2'd2; cfg_relu = 1'b1; cfg_mp = 1'b1; data_valid = 1'b1;
        job(2, 2, 0, 1, dc, dn);
        chk("t6_done_cycle", dc, 11);
        chk("t6_out_cnt", out_cnt, 6);
        tick();
        chk("t6_out_hold", out_cnt, 6);
        chk("t6_idle_bound", core.core_bound_level, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/arith_core_sequencer.md
ARITH_CORE_SEQUENCER -- requirements
Module: arith_core_sequencer

Interface
REQ-001 SHALL have parameter STEP_W, default 3, width of the core step index.
REQ-002 SHALL have parameter PIX_W, default 16, width of the output-pixel counter.
REQ-003 SHALL have parameter DRAIN_LAT, default 4, cycles from the last core_en to pipeline empty.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  job request; sampled only in IDLE.
REQ-007 SHALL have port abort  input  1  synchronous job cancel.
REQ-008 SHALL have port cfg_last_step  input  STEP_W  number of steps per pixel minus one.
REQ-009 SHALL have port cfg_pixels  input  PIX_W  number of output pixels in the job.
REQ-010 SHALL have port cfg_bound_level  input  2  saturation level for the core.
REQ-011 SHALL have port cfg_relu  input  1  ReLU enable for the job.
REQ-012 SHALL have port cfg_mp  input  1  max-pool enable for the job.
REQ-013 SHALL have port data_valid  input  1  operand buffer presents the current in/weight window.
REQ-014 SHALL have port data_ready  output  1  window consumed this cycle.
REQ-015 SHALL have port core_en  output  1  core enable.
REQ-016 SHALL have port core_step  output  STEP_W  core step index.
REQ-017 SHALL have port core_bound_level  output  2  latched bound level.
REQ-018 SHALL have port core_en_relu  output  1  latched ReLU enable.
REQ-019 SHALL have port core_en_mp  output  1  latched max-pool enable.
REQ-020 SHALL have port core_out_en  input  1  core result-valid strobe.
REQ-021 SHALL have port busy  output  1  high in every state except IDLE.
REQ-022 SHALL have port done  output  1  one-cycle job-complete pulse.
REQ-023 SHALL have port out_cnt  output  PIX_W  number of core_out_en pulses seen in the current job.

Function
REQ-024 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-025 IDLE with start=1 SHALL latch all cfg_* values, clear the step, pixel and out_cnt counters, and go to RUN; if cfg_pixels=0 it SHALL go to DONE instead.
REQ-026 start outside IDLE SHALL be ignored; cfg_* changes after latching SHALL have no effect.
REQ-027 In RUN, data_ready and core_en SHALL equal data_valid, combinationally, in the same cycle.
REQ-028 core_step SHALL equal the step counter.
REQ-029 Each accepted cycle (data_valid=1 in RUN) SHALL increment the step counter; at cfg_last_step the step counter SHALL wrap to 0 and the pixel counter SHALL increment.
REQ-030 data_valid=0 SHALL stall: core_en=0 and both counters hold.
REQ-031 Acceptance of the last step of pixel cfg_pixels-1 SHALL move the block to DRAIN on the next edge.
REQ-032 DRAIN SHALL last exactly DRAIN_LAT cycles with core_en=0, then go to DONE.
REQ-033 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-034 core_bound_level, core_en_relu and core_en_mp SHALL hold their latched values in RUN and DRAIN, because the core delays them internally by two cycles.
REQ-035 core_bound_level, core_en_relu and core_en_mp SHALL be 0 in IDLE and DONE.
REQ-036 out_cnt SHALL increment on every core_out_en=1 cycle while busy, saturate at all-ones, and hold its value in IDLE until the next start.
REQ-037 abort=1 in RUN or DRAIN SHALL force core_en=0 and data_ready=0 that cycle and go to IDLE without pulsing done.
REQ-038 abort SHALL take priority over stepping.
REQ-039 abort in IDLE or DONE SHALL be ignored.
REQ-040 A step wrap and a pixel increment in the same cycle SHALL be one atomic update, with no extra cycle.

Reset
REQ-041 reset=0 SHALL immediately force state IDLE and clear all counters and latched configuration.
REQ-042 During reset, data_ready, core_en, core_step, core_bound_level, core_en_relu, core_en_mp, busy, done and out_cnt SHALL all be 0.
REQ-043 Reset asserted mid-job SHALL discard the job, with no done pulse.

Structure
REQ-044 The state encoding and the defaults for STEP_W, PIX_W and DRAIN_LAT SHALL reside in the shared accelerator package.
REQ-045 The step/pixel counter pair SHALL be one sub-module, seq_step_counter (inc, clr, last_step, last_pixel, wrap, done flags).
REQ-046 Only FSM next-state and output decode SHALL be combinational; all other state SHALL be registered.

Verification
REQ-047 The bench SHALL cover: cfg_last_step=2, cfg_pixels=2, data_valid held 1 -> core_step 0,1,2,0,1,2 on six consecutive cycles, 4 DRAIN cycles, done pulse in cycle 11 after start.
REQ-048 The bench SHALL cover: same job with data_valid=0 for 3 cycles after the 2nd step -> core_step holds at 1, core_en=0, and done arrives 3 cycles later.
REQ-049 The bench SHALL cover: cfg_pixels=0 -> DONE the cycle after start, done=1, and core_en never asserted.
REQ-050 The bench SHALL cover: abort during RUN at step 1 of pixel 0 -> core_en=0 that cycle, IDLE next cycle, no done, and a new start accepted.
REQ-051 The bench SHALL cover: reset low mid-DRAIN -> all outputs 0 immediately, IDLE after release.
REQ-052 The bench SHALL cover: cfg_relu=1, cfg_mp=1, cfg_bound_level=2 with cfg inputs changed during RUN -> core_* keep the latched values, and out_cnt equals the number of core_out_en pulses.
